// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end. It keeps several in-order inst_sram requests in flight, cancels them by count on redirect, and buffers returns toward ID.
// Optional macro IF_FETCH_BYPASS_EN: when the queue is empty, a live return goes straight to ID in the same cycle.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_reset,
    input  logic [31:0] ex_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_allow_in,
    output logic        if_to_id_valid,
    output logic [64:0] to_id_data
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QCW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW  = $clog2(BUF_DEPTH + MAX_OUTSTANDING + 1);
    localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned QAW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outst;
    logic [CW-1:0]  cancel_cnt;
    logic [CW-1:0]  outst_nx;
    logic [CW-1:0]  live;
    logic           adef_stall;

    logic [31:0]    pc_fifo [MAX_OUTSTANDING];
    logic [PAW-1:0] pc_rd;
    logic [PAW-1:0] pc_wr;

    logic [64:0]    queue [BUF_DEPTH];
    logic [QAW-1:0] q_rd;
    logic [QAW-1:0] q_wr;
    logic [QCW-1:0] occ;

    logic           redirect;
    logic [31:0]    target;
    logic           credit_ok;
    logic           accept;
    logic           live_ret;
    logic           adef_enq;
    logic           enq;
    logic           deq;
    logic [64:0]    enq_data;

    function automatic logic [PAW-1:0] pc_inc(input logic [PAW-1:0] p);
        return (p == PAW'(MAX_OUTSTANDING - 1)) ? '0 : p + PAW'(1);
    endfunction

    function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
        return (p == QAW'(BUF_DEPTH - 1)) ? '0 : p + QAW'(1);
    endfunction

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = '0;
    assign inst_sram_wdata = '0;
    assign inst_sram_addr  = fetch_pc;

    assign redirect = csr_reset | br_taken;
    assign target   = csr_reset ? ex_entry : br_target;
    assign live     = outst - cancel_cnt;

    // A live request always has a queue slot reserved, so no return is ever dropped.
    assign credit_ok     = (SW'(live) + SW'(occ)) < SW'(BUF_DEPTH);
    assign inst_sram_req = resetn & ~adef_stall & (fetch_pc[1:0] == 2'b00)
                         & (outst < CW'(MAX_OUTSTANDING)) & credit_ok;

    assign accept   = inst_sram_req & inst_sram_addr_ok;
    assign live_ret = inst_sram_data_ok & (cancel_cnt == '0) & ~redirect;
    assign adef_enq = ~adef_stall & (fetch_pc[1:0] != 2'b00) & (live == '0)
                    & (occ != QCW'(BUF_DEPTH)) & ~redirect;
    assign outst_nx = outst + CW'(accept) - CW'(inst_sram_data_ok);
    assign enq_data = adef_enq ? {fetch_pc, 32'h0, 1'b1}
                               : {pc_fifo[pc_rd], inst_sram_rdata, 1'b0};

`ifdef IF_FETCH_BYPASS_EN
    logic bypass;
    assign bypass         = live_ret & (occ == '0);
    assign enq            = adef_enq | (live_ret & ~(bypass & id_allow_in));
    assign if_to_id_valid = ((occ != '0) | bypass) & ~redirect;
    assign to_id_data     = (occ != '0) ? queue[q_rd]
                          : bypass      ? {pc_fifo[pc_rd], inst_sram_rdata, 1'b0}
                          : '0;
`else
    assign enq            = adef_enq | live_ret;
    assign if_to_id_valid = (occ != '0) & ~redirect;
    assign to_id_data     = (occ != '0) ? queue[q_rd] : '0;
`endif

    assign deq = if_to_id_valid & id_allow_in & (occ != '0);

    always_ff @(posedge clk) begin
        if (accept && !redirect) pc_fifo[pc_wr] <= fetch_pc;
        if (enq) queue[q_wr] <= enq_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc   <= RESET_PC;
            outst      <= '0;
            cancel_cnt <= '0;
            adef_stall <= 1'b0;
            pc_rd      <= '0;
            pc_wr      <= '0;
            q_rd       <= '0;
            q_wr       <= '0;
            occ        <= '0;
        end else begin
            outst <= outst_nx;
            if (redirect) begin
                // Everything accepted up to and including this cycle is still owed a return.
                fetch_pc   <= target;
                cancel_cnt <= outst_nx;
                adef_stall <= 1'b0;
                pc_rd      <= '0;
                pc_wr      <= '0;
                q_rd       <= '0;
                q_wr       <= '0;
                occ        <= '0;
            end else begin
                if (accept) begin
                    pc_wr    <= pc_inc(pc_wr);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (inst_sram_data_ok) begin
                    if (cancel_cnt != '0) cancel_cnt <= cancel_cnt - CW'(1);
                    else                  pc_rd      <= pc_inc(pc_rd);
                end
                if (adef_enq) adef_stall <= 1'b1;
                if (enq)      q_wr <= q_inc(q_wr);
                if (deq)      q_rd <= q_inc(q_rd);
                occ <= occ + QCW'(enq) - QCW'(deq);
            end
        end
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end for the 5-stage LoongArch pipeline that replaces the single-request fetch stage. It keeps up to MAX_OUTSTANDING in-order requests in flight on the inst_sram request/addr_ok/data_ok bus and buffers returned instructions in a BUF_DEPTH-entry queue toward ID. On a CSR redirect or branch, it discards in-flight responses by count rather than by a blocking cancel state.

## Interface
- RESET_PC, 32'h1c000000, fetch address after reset
- MAX_OUTSTANDING, 2, max accepted-but-unreturned SRAM requests (1..8)
- BUF_DEPTH, 4, instruction queue entries (power of two, ≥ MAX_OUTSTANDING)
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- csr_reset  in  1  exception/ertn redirect; priority over branch
- ex_entry  in  32  redirect target when csr_reset
- br_taken  in  1  branch redirect
- br_target  in  32  redirect target when br_taken
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  fetch pc
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  oldest outstanding response valid
- inst_sram_rdata  in  32  response data
- id_allow_in  in  1  ID accepts this cycle
- if_to_id_valid  out  1  queue head valid
- to_id_data  out  65  {pc[31:0], inst[31:0], ex_adef}

## Operation
- State: fetch_pc; outst (unreturned count, includes cancelled); cancel_cnt; pc FIFO (depth MAX_OUTSTANDING) of live request pcs; instruction queue; adef_stall flag. Counter width $clog2(MAX_OUTSTANDING+1).
- live = outst − cancel_cnt. Issue when resetn, ~adef_stall, fetch_pc[1:0]==0, outst < MAX_OUTSTANDING, live + occupancy < BUF_DEPTH. This credit rule means a data_ok is never dropped for lack of space.
- req & addr_ok: push fetch_pc to pc FIFO, outst++, fetch_pc += 4. Address is held stable until addr_ok, except on redirect.
- data_ok: outst--. If cancel_cnt>0, cancel_cnt-- and drop. Otherwise pop pc FIFO and enqueue {pc, rdata, 0}.
- Misaligned fetch_pc (ADEF): no SRAM request. When live==0 and queue not full, enqueue {fetch_pc, 32'b0, 1}, then set adef_stall. Only a redirect clears it.
- Redirect r = csr_reset | br_taken. Target = csr_reset ? ex_entry : br_target.
  - fetch_pc ← target; queue and pc FIFO cleared; adef_stall ← 0.
  - cancel_cnt ← outst_next: every request accepted up to and including the redirect cycle that has not yet returned is cancelled.
  - A data_ok in the redirect cycle is dropped.
- ID handshake: pop on if_to_id_valid & id_allow_in.

## Timing
- During reset and for all outputs: inst_sram_req=0, if_to_id_valid=0, inst_sram_addr=RESET_PC, to_id_data=0 when empty. First request in the first cycle after resetn rises.
- inst_sram_req is combinational from registered state only; no path from br_taken or csr_reset to req.
- Latency: data_ok in cycle t → if_to_id_valid in t+1 (no-bypass build).
- Redirect cycle: if_to_id_valid forced 0. New-target request in r+1. Its instruction is visible no earlier than one cycle after its data_ok, after all cancelled returns.
- Simultaneous addr_ok, data_ok and redirect in one cycle: the counters net correctly, e.g. outst 2 → 2 and cancel_cnt → 2.
- Back-to-back ID pops with continuous data_ok sustain 1 instr/cycle when MAX_OUTSTANDING ≥ 2.

## Configuration
- IF_FETCH_BYPASS_EN defined: queue empty, non-cancelled data_ok, no redirect → to_id_data driven directly from rdata and the pc FIFO head with if_to_id_valid=1 in the same cycle. If id_allow_in=1 the entry is not written to the queue.
- Undefined: every instruction passes through the queue (1-cycle minimum latency). There is no combinational path from rdata to to_id_data.

## Test plan
- Reset release, SRAM addr_ok always 1, data_ok 1 cycle later, id_allow_in=1 → addrs 1c000000, 1c000004, … issued every cycle; ID receives the same pcs in order, ex_adef=0.
- id_allow_in=0 for 10 cycles, MAX_OUTSTANDING=2, BUF_DEPTH=4 → req drops once live+occupancy=4; no data lost; 4 entries drain in order when allow returns.
- 2 requests outstanding, br_taken with br_target=1c000100 → both returns dropped (cancel_cnt 2→0); the next delivered pc is 1c000100.
- csr_reset and br_taken in the same cycle, ex_entry=1c008000 → fetch resumes at 1c008000.
- Redirect to 1c000102 → no SRAM request; one entry {1c000102, 0, 1} delivered; fetch stalls until the next redirect.
- Redirect coincident with addr_ok and data_ok → that data is dropped; the newly accepted request is also cancelled; no stale instruction reaches ID.
